// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word requests, buffers returns for decode.
// Latency: request accepted in cycle N, response in N+k, instr_valid from the buffer in N+k+1.
// Backpressure: requests only issue while in-flight plus buffered entries leave a free buffer slot.
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   typedef logic [CW-1:0] cnt_t;
   localparam logic [CW:0] LP_DEPTH = (CW+1)'(BUF_DEPTH);

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_head_pc;
   cnt_t                  r_outstanding;
   cnt_t                  r_drop_cnt;
   cnt_t                  r_count;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];

   logic                  w_credit;
   logic                  w_accept;
   logic                  w_rsp;
   logic                  w_drop;
   logic                  w_wr;
   logic                  w_pop;
   cnt_t                  w_out_next;
   logic [ADDR_WIDTH-1:0] w_redir_pc;

   // A response slot is reserved at request time, so in-flight plus buffered bounds issue.
   assign w_credit       = ({1'b0, r_outstanding} + {1'b0, r_count}) < LP_DEPTH;
   assign imem_req_valid = rst_n & ~redirect_valid & w_credit;
   assign imem_req_addr  = r_pc;
   assign w_accept       = imem_req_valid & imem_req_ready;

   // Responses with nothing in flight (e.g. left over from before a reset) are ignored.
   assign w_rsp      = imem_rsp_valid & (r_outstanding != '0);
   assign w_drop     = w_rsp & (r_drop_cnt != '0);
   assign w_wr       = w_rsp & ~w_drop & ~redirect_valid;
   assign w_out_next = r_outstanding + cnt_t'(w_accept) - cnt_t'(w_rsp);
   assign w_redir_pc = redirect_pc & ~ADDR_WIDTH'(3);

   assign instr_valid = rst_n & (r_count != '0);
   assign instr       = r_buf[r_rd_ptr];
   assign instr_pc    = r_head_pc;
   assign w_pop       = instr_valid & instr_ready & ~redirect_valid;

   // PC, counters and buffer pointers; a redirect flushes and marks every in-flight request stale.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_head_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
      end else if (redirect_valid) begin
         r_pc          <= w_redir_pc;
         r_head_pc     <= w_redir_pc;
         r_outstanding <= w_out_next;
         r_drop_cnt    <= w_out_next;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (w_accept) r_pc <= r_pc + ADDR_WIDTH'(4);
         if (w_drop)   r_drop_cnt <= r_drop_cnt - cnt_t'(1);
         if (w_wr)     r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PW'(1);
            r_head_pc <= r_head_pc + ADDR_WIDTH'(4);
         end
         r_count <= r_count + cnt_t'(w_wr) - cnt_t'(w_pop);
      end
   end

   // Instruction storage; contents need no reset since r_count gates visibility.
   always_ff @(posedge clk) begin
      if (w_wr) r_buf[r_wr_ptr] <= imem_rsp_data;
   end

   // Credit accounting must never let a response land in a full buffer.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr) assert (r_count != cnt_t'(BUF_DEPTH));
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model: queue of in-flight requests (stale flag) and queue of buffered words
   logic [31:0] m_pc, m_head;
   bit          q_fly[$];
   logic [31:0] q_buf[$];
   logic        exp_req_valid, exp_instr_valid;

   // memory: ordered queue of accepted addresses with due cycle
   typedef struct { logic [31:0] a; int due; } mreq_t;
   mreq_t mq[$];
   int    lat = 1;
   int    cyc = 0;
   int    cyc0 = 0;
   bit    mem_fired;
   bit    spur = 0;

   logic [31:0] acc_log[$], dlv_pc[$], dlv_dat[$], dlv_cyc[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return {32'h0, q[i]};
      return 'x;
   endfunction

   task automatic mark();
      cyc0 = cyc;
      acc_log.delete(); dlv_pc.delete(); dlv_dat.delete(); dlv_cyc.delete();
   endtask

   task automatic drive_mem();
      mem_fired = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mq[0].a >> 2;
         mem_fired = 1;
      end else if (spur) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
   endtask

   // compare DUT outputs against the model, then log observed handshakes
   task automatic check_cycle();
      exp_req_valid   = rst_n && !redirect_valid && (q_fly.size() + q_buf.size() < 2);
      exp_instr_valid = rst_n && (q_buf.size() > 0);
      chk("req_valid", {63'h0, imem_req_valid}, {63'h0, exp_req_valid});
      if (exp_req_valid) chk("req_addr", {32'h0, imem_req_addr}, {32'h0, m_pc});
      chk("instr_valid", {63'h0, instr_valid}, {63'h0, exp_instr_valid});
      if (exp_instr_valid) begin
         chk("instr", {32'h0, instr}, {32'h0, q_buf[0]});
         chk("instr_pc", {32'h0, instr_pc}, {32'h0, m_head});
      end
      if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
      if (instr_valid && instr_ready && !redirect_valid) begin
         dlv_pc.push_back(instr_pc);
         dlv_dat.push_back(instr);
         dlv_cyc.push_back(32'(cyc - cyc0));
      end
   endtask

   task automatic update_model();
      bit pop, st;
      if (exp_req_valid && imem_req_ready) mq.push_back('{a: m_pc, due: cyc + lat});
      if (mem_fired) void'(mq.pop_front());
      if (!rst_n) begin
         m_pc = 32'h0; m_head = 32'h0;
         q_fly.delete(); q_buf.delete();
      end else begin
         pop = exp_instr_valid && instr_ready && !redirect_valid;
         if (pop) begin
            void'(q_buf.pop_front());
            m_head = m_head + 32'd4;
         end
         if (imem_rsp_valid && q_fly.size() > 0) begin
            st = q_fly.pop_front();
            if (!st && !redirect_valid) q_buf.push_back(imem_rsp_data);
         end
         if (redirect_valid) begin
            q_buf.delete();
            m_pc   = redirect_pc & ~32'h3;
            m_head = redirect_pc & ~32'h3;
            foreach (q_fly[i]) q_fly[i] = 1'b1;
         end else if (exp_req_valid && imem_req_ready) begin
            q_fly.push_back(1'b0);
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         #1 check_cycle();
         @(posedge clk);
         update_model();
         @(negedge clk);
         drive_mem();
      end
   endtask

   task automatic reset_pulse(input int n);
      rst_n = 1'b0;
      step(n);
      mq.delete();
      drive_mem();
   endtask

   initial begin
      rst_n = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = 32'h0; instr_ready = 1'b1;
      m_pc = 32'h0; m_head = 32'h0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      @(negedge clk);
      drive_mem();

      // reset state
      reset_pulse(2);
      #1 chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);

      // zero-wait streaming
      lat = 1; rst_n = 1'b1; mark();
      step(8);
      for (int i = 0; i < 4; i++) begin
         chk("s1_pc", at(dlv_pc, i), 64'(4 * i));
         chk("s1_dat", at(dlv_dat, i), 64'(i));
      end
      chk("s1_first_cycle", at(dlv_cyc, 0), 64'd2);

      // decode stalled: only two requests go out
      reset_pulse(1);
      rst_n = 1'b1; instr_ready = 1'b0; mark();
      step(6);
      #1 chk("s2_req_cnt", 64'(acc_log.size()), 64'd2);
      chk("s2_req_valid", {63'h0, imem_req_valid}, 64'h0);
      instr_ready = 1'b1;
      step(6);
      chk("s2_pop0", at(dlv_pc, 0), 64'h0);
      chk("s2_pop1", at(dlv_pc, 1), 64'h4);
      chk("s2_resume", at(acc_log, 2), 64'h8);

      // memory not ready: address held
      reset_pulse(1);
      rst_n = 1'b1; imem_req_ready = 1'b0; mark();
      step(3);
      #1 chk("s3_no_acc", 64'(acc_log.size()), 64'd0);
      chk("s3_addr", {32'h0, imem_req_addr}, 64'h0);
      imem_req_ready = 1'b1;
      step(4);
      chk("s3_acc0", at(acc_log, 0), 64'h0);
      chk("s3_acc1", at(acc_log, 1), 64'h4);

      // redirect with two requests in flight
      reset_pulse(1);
      lat = 3; rst_n = 1'b1; instr_ready = 1'b0; mark();
      step(2);
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103; mark();
      step(1);
      redirect_valid = 1'b0;
      step(10);
      chk("s4_acc0", at(acc_log, 0), 64'h100);
      chk("s4_pc0", at(dlv_pc, 0), 64'h100);
      chk("s4_dat0", at(dlv_dat, 0), 64'h40);

      // redirect coincident with a response, a pop and a buffered entry
      reset_pulse(3);
      lat = 2; rst_n = 1'b1; instr_ready = 1'b0; mark();
      step(3);
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; mark();
      step(1);
      redirect_valid = 1'b0;
      #1 chk("s5_flushed", {63'h0, instr_valid}, 64'h0);
      step(8);
      chk("s5_pc0", at(dlv_pc, 0), 64'h200);
      chk("s5_dat0", at(dlv_dat, 0), 64'h80);
      chk("s5_pc1", at(dlv_pc, 1), 64'h204);

      // back-to-back redirects: last wins
      redirect_valid = 1'b1; redirect_pc = 32'h300; mark();
      step(1);
      redirect_pc = 32'h406;
      step(1);
      redirect_valid = 1'b0;
      step(8);
      chk("s6_acc0", at(acc_log, 0), 64'h404);
      chk("s6_pc0", at(dlv_pc, 0), 64'h404);

      // reset mid-stream with two outstanding, late responses ignored
      reset_pulse(3);
      lat = 3; rst_n = 1'b1; instr_ready = 1'b1; mark();
      step(2);
      rst_n = 1'b0;
      step(1);
      #1 chk("s7_rst_req", {63'h0, imem_req_valid}, 64'h0);
      chk("s7_rst_iv", {63'h0, instr_valid}, 64'h0);
      step(2);
      mq.delete();
      rst_n = 1'b1; spur = 1; drive_mem(); mark();
      step(1);
      spur = 0; drive_mem();
      step(6);
      chk("s7_pc0", at(dlv_pc, 0), 64'h0);
      chk("s7_dat0", at(dlv_dat, 0), 64'h0);

      // PC wrap
      lat = 1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB; mark();
      step(1);
      redirect_valid = 1'b0;
      step(8);
      chk("s8_acc0", at(acc_log, 0), 64'hFFFF_FFF8);
      chk("s8_acc1", at(acc_log, 1), 64'hFFFF_FFFC);
      chk("s8_acc2", at(acc_log, 2), 64'h0);
      chk("s8_pc2", at(dlv_pc, 2), 64'h0);
      chk("s8_dat1", at(dlv_dat, 1), 64'h3FFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
